freq_divider_bank: RTL and testbench

//  Multi-channel programmable clock/tone divider. Each of NUM_CH channels

---
 rtl/freq_divider_bank.sv | 115 +++++++++++
 tb/tb_freq_divider_bank.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_divider_bank.sv
// Bank of NUM_CH programmable square-wave dividers with per-edge tick pulses.
// Period changes are taken only at output edges; a stop always finishes low.
module freq_divider_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 21,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] sclk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] running_o
);

  // Per-channel state: STOPPED while active is zero, RUN otherwise.
  // running_o is this state bit, so it doubles as the FSM debug view.
  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  pending_q [NUM_CH];
  logic [CNT_W-1:0]  pending_d [NUM_CH];
  logic [CNT_W-1:0]  active_q  [NUM_CH];
  logic [CNT_W-1:0]  active_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [NUM_CH-1:0] sclk_q;
  logic [NUM_CH-1:0] sclk_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] run_state;
  logic              wr_ok;

  assign wr_ok = wr_en_i && ({1'b0, wr_ch_i} < NUM_CH_W);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      run_state[i] = (active_q[i] != '0) ? ST_RUN : ST_STOPPED;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pending_d[i] = pending_q[i];
      active_d[i]  = active_q[i];
      cnt_d[i]     = cnt_q[i];
      sclk_d[i]    = sclk_q[i];
      tick_d[i]    = 1'b0;

      // A write always lands in pending; the active period below still
      // sees the old pending value this cycle.
      if (wr_ok && (wr_ch_i == CH_W'(i))) begin
        pending_d[i] = wr_data_i;
      end

      if (sync_i) begin
        active_d[i] = pending_q[i];
        cnt_d[i]    = '0;
        sclk_d[i]   = 1'b0;
      end else begin
        case (run_state[i])
          ST_STOPPED: begin
            active_d[i] = pending_q[i];
            cnt_d[i]    = '0;
            sclk_d[i]   = 1'b0;
          end
          default: begin
            if (cnt_q[i] == (active_q[i] - 1'b1)) begin
              cnt_d[i]  = '0;
              sclk_d[i] = ~sclk_q[i];
              tick_d[i] = 1'b1;
              // A stop requested on a rising boundary is deferred so the
              // high half-period completes before the channel goes idle.
              if (sclk_q[i] || (pending_q[i] != '0)) begin
                active_d[i] = pending_q[i];
              end
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
        cnt_q[i]     <= '0;
      end
      sclk_q <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
      sclk_q <= sclk_d;
      tick_q <= tick_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign tick_o    = tick_q;
  assign running_o = run_state;

endmodule

// File: tb/tb_freq_divider_bank.sv
// Bench for freq_divider_bank: directed scenarios plus random traffic against
// an edge-countdown reference model of each channel.
module tb_freq_divider_bank;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [CW-1:0]  wr_data = '0;
  logic           sync = 1'b0;
  logic [NCH-1:0] sclk_o;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] running_o;

  int checks = 0;
  int errors = 0;

  freq_divider_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
    .wr_data_i(wr_data), .sync_i(sync), .sclk_o(sclk_o), .tick_o(tick_o),
    .running_o(running_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Reference: each channel knows its level, its half-period (0 = stopped)
  // and how many clock edges remain until its next output edge.
  int m_pend [NCH];
  int m_cur  [NCH];
  int m_left [NCH];
  bit m_lvl  [NCH];
  bit m_tk   [NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pend[c] = 0; m_cur[c] = 0; m_left[c] = 0; m_lvl[c] = 0; m_tk[c] = 0;
    end
  endfunction

  function automatic void model_edge(bit we, int wch, int wd, bit sy);
    for (int c = 0; c < NCH; c++) begin
      int p;
      p = m_pend[c];
      m_tk[c] = 0;
      if (sy) begin
        m_lvl[c] = 0; m_cur[c] = p; m_left[c] = p;
      end else if (m_cur[c] == 0) begin
        m_lvl[c] = 0;
        if (p != 0) begin m_cur[c] = p; m_left[c] = p; end
      end else begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_tk[c] = 1;
          m_lvl[c] = !m_lvl[c];
          if (!(m_lvl[c] && p == 0)) m_cur[c] = p;
          m_left[c] = m_cur[c];
        end
      end
      if (we && wch == c) m_pend[c] = wd;
    end
  endfunction

  function automatic logic [3*NCH-1:0] exp_vec();
    logic [NCH-1:0] s, t, r;
    for (int c = 0; c < NCH; c++) begin
      s[c] = m_lvl[c]; t[c] = m_tk[c]; r[c] = (m_cur[c] != 0);
    end
    return {s, t, r};
  endfunction

  task automatic wr(input int ch, input int n);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = CW'(n);
  endtask

  task automatic step();
    model_edge(wr_en, int'(wr_ch), int'(wr_data), sync);
    @(posedge clk); #1;
    wr_en = 1'b0; sync = 1'b0;
  endtask

  // Steps until channel ch ticks (bounded); optionally writes wr_n on step wr_at.
  task automatic measure(input int ch, input int wr_at, input int wr_n,
                         output int len, output int bad);
    bit got;
    len = 0; bad = 0; got = 0;
    while (!got && len < 600) begin
      if (len == wr_at) wr(ch, wr_n);
      step();
      len++;
      if ({sclk_o, tick_o, running_o} !== exp_vec()) bad++;
      got = tick_o[ch];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_ch = 2'($urandom_range(0, 2));
      wr_data = CW'($urandom_range(1, 9));
      @(posedge clk); #1;
      checks++;
      if ({sclk_o, tick_o, running_o} !== '0) begin
        errors++; $display("FAIL reset_hold got %b exp 0", {sclk_o, tick_o, running_o});
      end
    end
    wr_en = 1'b0; rst_n = 1'b1; model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({sclk_o, tick_o, running_o} !== 9'd0) begin
        errors++; $display("FAIL reset_release got %b exp 0", {sclk_o, tick_o, running_o});
      end
    end
  endtask

  task automatic test_basic();
    int ticks, highs;
    wr(0, 3); step();
    step();
    checks++;
    if (running_o[0] !== 1'b1) begin
      errors++; $display("FAIL basic_running got %b exp 1", running_o[0]);
    end
    ticks = 0; highs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if ({sclk_o, tick_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL basic_model got %b exp %b", {sclk_o, tick_o, running_o}, exp_vec());
      end
      ticks += int'(tick_o[0]); highs += int'(sclk_o[0]);
    end
    checks++;
    if (ticks !== 10 || highs !== 15) begin
      errors++; $display("FAIL basic_counts got ticks %0d high %0d exp 10 15", ticks, highs);
    end
  endtask

  task automatic test_retune();
    int len, bad;
    int exp_len [5] = '{0, 5, 2, 2, 5};
    int got_len [5];
    measure(1, 0, 5, len, bad);          // start channel, wait for first rise
    got_len[0] = len;
    measure(1, 2, 2, got_len[1], bad);   // mid-half write: still 5 then 2
    measure(1, -1, 0, got_len[2], bad);
    measure(1, 0, 5, got_len[3], bad);   // back to 5 from the next boundary
    measure(1, -1, 0, got_len[4], bad);
    checks++;
    if (got_len[0] !== 7 || got_len[1] !== exp_len[1] || got_len[2] !== exp_len[2] ||
        got_len[3] !== exp_len[3] || got_len[4] !== exp_len[4]) begin
      errors++; $display("FAIL retune_mid got %0d %0d %0d %0d %0d exp 7 5 2 2 5",
                         got_len[0], got_len[1], got_len[2], got_len[3], got_len[4]);
    end
    measure(1, 4, 2, got_len[0], bad);   // write coincides with the boundary
    measure(1, -1, 0, got_len[1], bad);
    measure(1, -1, 0, got_len[2], bad);
    checks++;
    if (got_len[0] !== 5 || got_len[1] !== 5 || got_len[2] !== 2) begin
      errors++; $display("FAIL retune_boundary got %0d %0d %0d exp 5 5 2",
                         got_len[0], got_len[1], got_len[2]);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL retune_model got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_stop();
    int l1, l2, l3, bad, ticks;
    measure(2, 0, 4, l1, bad);
    measure(2, -1, 0, l2, bad);
    checks++;
    if (l1 !== 6 || l2 !== 4 || sclk_o[2] !== 1'b0) begin
      errors++; $display("FAIL stop_setup got %0d %0d sclk %b exp 6 4 0", l1, l2, sclk_o[2]);
    end
    measure(2, 1, 0, l1, bad);           // stop requested while low
    checks++;
    if (l1 !== 4 || sclk_o[2] !== 1'b1 || running_o[2] !== 1'b1) begin
      errors++; $display("FAIL stop_low_rise got %0d %b %b exp 4 1 1", l1, sclk_o[2], running_o[2]);
    end
    measure(2, -1, 0, l2, bad);
    checks++;
    if (l2 !== 4 || sclk_o[2] !== 1'b0 || running_o[2] !== 1'b0) begin
      errors++; $display("FAIL stop_low_end got %0d %b %b exp 4 0 0", l2, sclk_o[2], running_o[2]);
    end
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ticks += int'(tick_o[2]);
      checks++;
      if ({sclk_o, tick_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL stop_model got %b exp %b", {sclk_o, tick_o, running_o}, exp_vec());
      end
    end
    checks++;
    if (ticks !== 0) begin
      errors++; $display("FAIL stop_quiet got %0d ticks exp 0", ticks);
    end
    measure(2, 0, 4, l1, bad);
    measure(2, 1, 0, l3, bad);           // stop requested while high
    checks++;
    if (l3 !== 4 || sclk_o[2] !== 1'b0 || running_o[2] !== 1'b0 || bad !== 0) begin
      errors++; $display("FAIL stop_high got %0d %b %b bad %0d exp 4 0 0 0",
                         l3, sclk_o[2], running_o[2], bad);
    end
  endtask

  task automatic test_sync();
    int l0, l1, l2, bad;
    wr(1, 6); step();
    for (int i = 0; i < 15; i++) step();
    sync = 1'b1; step();
    checks++;
    if (sclk_o[1:0] !== 2'b00 || running_o[1:0] !== 2'b11 || tick_o[1:0] !== 2'b00) begin
      errors++; $display("FAIL sync_clear got %b %b %b exp 00 11 00", sclk_o[1:0], running_o[1:0], tick_o[1:0]);
    end
    measure(0, -1, 0, l0, bad);
    measure(1, -1, 0, l1, bad);
    measure(1, -1, 0, l2, bad);
    checks++;
    if (l0 !== 3 || l1 !== 3 || l2 !== 6 || sclk_o[1] !== 1'b0 || bad !== 0) begin
      errors++; $display("FAIL sync_phase got %0d %0d %0d bad %0d exp 3 3 6 0", l0, l1, l2, bad);
    end
    wr(0, 4); sync = 1'b1; step();        // write during sync: sync loads old N=3
    measure(0, -1, 0, l0, bad);
    measure(0, -1, 0, l1, bad);
    checks++;
    if (l0 !== 3 || l1 !== 4) begin
      errors++; $display("FAIL sync_write got %0d %0d exp 3 4", l0, l1);
    end
  endtask

  task automatic test_corner();
    int l0, bad, ones, ticks;
    measure(0, 0, 1, l0, bad);
    measure(0, -1, 0, l0, bad);
    checks++;
    if (l0 !== 1) begin
      errors++; $display("FAIL corner_n1_len got %0d exp 1", l0);
    end
    ones = 0;
    for (int i = 0; i < 10; i++) begin step(); ones += int'(tick_o[0]); end
    checks++;
    if (ones !== 10 || bad !== 0) begin
      errors++; $display("FAIL corner_n1_tick got %0d bad %0d exp 10 0", ones, bad);
    end
    wr(2, 255);
    ticks = 0;
    for (int i = 0; i < 1030; i++) begin
      step();
      ticks += int'(tick_o[2]);
      checks++;
      if ({sclk_o, tick_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL corner_max_model got %b exp %b", {sclk_o, tick_o, running_o}, exp_vec());
      end
    end
    checks++;
    if (ticks !== 4) begin
      errors++; $display("FAIL corner_max_ticks got %0d exp 4", ticks);
    end
    for (int c = 0; c < NCH; c++) begin wr(c, 0); step(); end
    for (int i = 0; i < 600; i++) step();
    checks++;
    if (running_o !== 3'b000 || sclk_o !== 3'b000) begin
      errors++; $display("FAIL corner_all_stop got %b %b exp 000 000", running_o, sclk_o);
    end
    wr(3, 9); step();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({sclk_o, tick_o, running_o} !== 9'd0) begin
        errors++; $display("FAIL corner_bad_ch got %b exp 0", {sclk_o, tick_o, running_o});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr(int'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12)));
      end
      if ($urandom_range(0, 39) == 0) sync = 1'b1;
      step();
      checks++;
      if ({sclk_o, tick_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d got %b exp %b", i, {sclk_o, tick_o, running_o}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 2); step(); wr(1, 3); step();
    for (int i = 0; i < 9; i++) step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({sclk_o, tick_o, running_o} !== 9'd0) begin
      errors++; $display("FAIL reset_mid_async got %b exp 0", {sclk_o, tick_o, running_o});
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(1, 2);
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({sclk_o, tick_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL reset_mid_restart got %b exp %b", {sclk_o, tick_o, running_o}, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_retune();
    test_stop();
    test_sync();
    test_corner();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
